// File: rtl/vga_timing_pkg.sv
// Purpose: shared widths, default 640x480@60 timing and derived raster constants.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents:
//   coord_t        - 10-bit unsigned scan coordinate
//   DEF_H_*/DEF_V_* - default porch/sync/active sizes
//   H_TOTAL, V_TOTAL, HS_START/HS_END, VS_START/VS_END - derived from the defaults
package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Default 640x480 @ 60 Hz timing (25 MHz pixel rate).
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Sync pulse occupies [START, END) in counter space.
  localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int HS_END   = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int VS_END   = VS_START + DEF_V_SYNC;

  // Narrow an elaboration-time integer to coordinate width.
  function automatic coord_t to_coord(input int value);
    return coord_t'(value);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Purpose: modulo-TOTAL raster axis counter with look-ahead next value.
// Latency: count updates on the clk edge where en=1; next_count is combinational.
// Backpressure: none; en is a pure advance strobe.
//
// Ports:
//   clk, rst       - clock, synchronous active-low reset (loads TOTAL-1)
//   en             - advance by one (wrapping TOTAL-1 -> 0) on this edge
//   count          - registered current position
//   next_count     - value count will take on this edge
//   wrap           - count is at its terminal value TOTAL-1 (not qualified by en)
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = H_TOTAL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COORD_W-1:0] count,
  output logic [COORD_W-1:0] next_count,
  output logic               wrap
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);

  assign wrap = (count == LAST);

  always_comb begin
    next_count = count;
    if (en) begin
      next_count = wrap ? '0 : count + coord_t'(1);
    end
  end

  // Resetting to the terminal value means the first advance lands on 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= LAST;
    end else begin
      count <= next_count;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: VGA raster timing (x/y scan, sync, blank, pixel clock, frame pulse).
// Latency: all outputs update together on the pix_en edge; 0 cycles after the counters.
// Backpressure: none; free-running raster, consumers must keep up.
//
// Ports:
//   clk, rst          - 50 MHz clock, synchronous active-low reset
//   x, y              - current scan coordinate (registered)
//   active_pixels     - x/y inside the visible area (registered)
//   VGA_HS, VGA_VS    - active-low syncs (registered)
//   VGA_BLANK_N       - same as active_pixels
//   VGA_SYNC_N        - tied low
//   VGA_CLK           - clk/2 pixel clock, rises mid-pixel
//   pix_en            - high in the clk whose closing edge advances the raster
//   frame_start       - high for one clk after the raster enters (0,0)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               active_pixels,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic               VGA_CLK,
  output logic               pix_en,
  output logic               frame_start
);

  localparam int LINE_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_VIS   = to_coord(H_ACTIVE);
  localparam coord_t V_VIS   = to_coord(V_ACTIVE);
  localparam coord_t HS_BEG  = to_coord(H_ACTIVE + H_FP);
  localparam coord_t HS_FIN  = to_coord(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_BEG  = to_coord(V_ACTIVE + V_FP);
  localparam coord_t VS_FIN  = to_coord(V_ACTIVE + V_FP + V_SYNC);

  logic   phase;
  logic   h_en;
  logic   v_en;
  coord_t h_cnt;
  coord_t h_nxt;
  coord_t v_cnt;
  coord_t v_nxt;
  logic   h_wrap;
  logic   v_wrap;

  // Pixel rate is clk/2: counters move on every second edge.
  assign h_en = phase;
  assign v_en = phase & h_wrap;

  vga_axis_counter #(.TOTAL(LINE_TOTAL)) u_h_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (h_en),
    .count      (h_cnt),
    .next_count (h_nxt),
    .wrap       (h_wrap)
  );

  vga_axis_counter #(.TOTAL(FRAME_LINES)) u_v_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (v_en),
    .count      (v_cnt),
    .next_count (v_nxt),
    .wrap       (v_wrap)
  );

  // Decode from the look-ahead values so the registered flags line up with
  // the coordinate registers that load on the same edge.
  logic act_nxt;
  logic hs_nxt;
  logic vs_nxt;
  logic fs_nxt;

  always_comb begin
    act_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    hs_nxt  = !((h_nxt >= HS_BEG) && (h_nxt < HS_FIN));
    vs_nxt  = !((v_nxt >= VS_BEG) && (v_nxt < VS_FIN));
    // Both axes sitting on their last value while advancing means we land on (0,0).
    fs_nxt  = h_en & h_wrap & v_wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase         <= 1'b0;
      active_pixels <= 1'b0;
      VGA_HS        <= 1'b1;
      VGA_VS        <= 1'b1;
      frame_start   <= 1'b0;
    end else begin
      phase         <= ~phase;
      active_pixels <= act_nxt;
      VGA_HS        <= hs_nxt;
      VGA_VS        <= vs_nxt;
      frame_start   <= fs_nxt;
    end
  end

  assign x           = h_cnt;
  assign y           = v_cnt;
  assign pix_en      = phase;
  assign VGA_CLK     = phase;
  assign VGA_BLANK_N = active_pixels;
  assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose: scoreboard bench for vga_timing_gen (default timing plus a shrunken raster).
// Latency: expected state for each clk edge is queued before that edge, checked 1 time unit after.
// Backpressure: n/a.
module tb_vga_timing_gen;

  // Shrunken raster so whole frames fit in a short run: 25 x 13.
  localparam int SH_A = 16, SH_FP = 2, SH_S = 4, SH_BP = 3;
  localparam int SV_A = 6,  SV_FP = 2, SV_S = 2, SV_BP = 3;
  localparam int S_HT = SH_A + SH_FP + SH_S + SH_BP;
  localparam int S_VT = SV_A + SV_FP + SV_S + SV_BP;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       blank;
    logic       sync;
    logic       hs;
    logic       vs;
    logic       vclk;
    logic       pe;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  logic [9:0] x_a, y_a, x_b, y_b;
  logic act_a, hs_a, vs_a, blank_a, sync_a, vclk_a, pe_a, fs_a;
  logic act_b, hs_b, vs_b, blank_b, sync_b, vclk_b, pe_b, fs_b;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst(rst_a), .x(x_a), .y(y_a), .active_pixels(act_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(blank_a), .VGA_SYNC_N(sync_a),
    .VGA_CLK(vclk_a), .pix_en(pe_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
    .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .x(x_b), .y(y_b), .active_pixels(act_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(blank_b), .VGA_SYNC_N(sync_b),
    .VGA_CLK(vclk_b), .pix_en(pe_b), .frame_start(fs_b)
  );

  obs_t q_a[$];
  obs_t q_b[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done_a = 1'b0;
  bit   done_b = 1'b0;

  // Reference: n = clk edges since the last reset edge. Pixel tick k = n/2;
  // tick 1 is pixel (0,0); pixels are numbered row-major and wrap per frame.
  function automatic obs_t model(input int n, input int ha, input int hfp, input int hsw,
                                 input int hbp, input int va, input int vfp, input int vsw,
                                 input int vbp);
    obs_t o;
    int ht, vt, k, p, h, v;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    k  = n / 2;
    o.pe   = (n % 2) == 1;
    o.vclk = (n % 2) == 1;
    o.sync = 1'b0;
    if (k == 0) begin
      o.x = 10'(ht - 1); o.y = 10'(vt - 1);
      o.act = 1'b0; o.hs = 1'b1; o.vs = 1'b1; o.fs = 1'b0;
    end else begin
      p = (k - 1) % (ht * vt);
      h = p % ht;
      v = p / ht;
      o.x   = 10'(h);
      o.y   = 10'(v);
      o.act = (h < ha) && (v < va);
      o.hs  = !((h >= ha + hfp) && (h < ha + hfp + hsw));
      o.vs  = !((v >= va + vfp) && (v < va + vfp + vsw));
      o.fs  = (p == 0) && ((n % 2) == 0);
    end
    o.blank = o.act;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("x=%0d y=%0d act=%b blank=%b sync_n=%b hs=%b vs=%b vga_clk=%b pix_en=%b fs=%b",
                     o.x, o.y, o.act, o.blank, o.sync, o.hs, o.vs, o.vclk, o.pe, o.fs);
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got {%s} want {%s}", name, $time, fmt(got), fmt(want));
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d want %0d", name, $time, got, want);
    end
  endtask

  // Stimulus A: default timing. Reset 3 clk, run two full lines, reset at (300,2).
  initial begin
    int n = 0;
    int hold = 3;
    bit mid_done = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (hold == 0 && !mid_done && n == 2 * (2 * 800 + 300 + 1)) begin
        hold = $urandom_range(1, 3);
        mid_done = 1'b1;
      end
      if (hold > 0) begin rst_a = 1'b0; hold--; n = 0; end
      else begin rst_a = 1'b1; n++; end
      q_a.push_back(model(n, 640, 16, 96, 48, 480, 10, 2, 33));
    end
    done_a = 1'b1;
  end

  // Stimulus B: shrunken raster, several frames, a mid-frame reset, then random resets.
  initial begin
    int n = 0;
    int hold = 3;
    bit mid_done = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      if (hold == 0 && !mid_done && n == 2 * (2 * S_HT * S_VT + 4 * S_HT + 10 + 1)) begin
        hold = 1;
        mid_done = 1'b1;
      end else if (hold == 0 && mid_done && $urandom_range(0, 1499) == 0) begin
        hold = $urandom_range(1, 3);
      end
      if (hold > 0) begin rst_b = 1'b0; hold--; n = 0; end
      else begin rst_b = 1'b1; n++; end
      q_b.push_back(model(n, SH_A, SH_FP, SH_S, SH_BP, SV_A, SV_FP, SV_S, SV_BP));
    end
    done_b = 1'b1;
  end

  // Monitor A: per-clk scoreboard plus HS low-pulse width in clk.
  initial begin
    int hs_run = 0;
    obs_t e;
    forever begin
      @(posedge clk); #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check_obs("a_state", {x_a, y_a, act_a, blank_a, sync_a, hs_a, vs_a, vclk_a, pe_a, fs_a}, e);
      end
      if (!rst_a) hs_run = 0;
      else if (!hs_a) hs_run++;
      else if (hs_run > 0) begin
        check_int("a_hs_low_clk", hs_run, 2 * 96);
        hs_run = 0;
      end
    end
  end

  // Monitor B: per-clk scoreboard plus frame period and visible-pixel count.
  initial begin
    int since_fs = -1;
    int act_ticks = 0;
    obs_t e;
    forever begin
      @(posedge clk); #1;
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check_obs("b_state", {x_b, y_b, act_b, blank_b, sync_b, hs_b, vs_b, vclk_b, pe_b, fs_b}, e);
      end
      if (!rst_b) begin
        since_fs = -1;
        act_ticks = 0;
      end else begin
        if (since_fs >= 0) since_fs++;
        if (pe_b && act_b) act_ticks++;
        if (fs_b) begin
          if (since_fs >= 0) begin
            check_int("b_frame_clk", since_fs, 2 * S_HT * S_VT);
            check_int("b_active_ticks", act_ticks, SH_A * SV_A);
          end
          since_fs = 0;
          act_ticks = 0;
        end
      end
    end
  end

  initial begin
    wait (done_a && done_b);
    repeat (3) @(posedge clk);
    #2;
    check_int("a_queue_drain", q_a.size(), 0);
    check_int("b_queue_drain", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
